// File: rtl/conv_output_streamer_if.sv
// -----------------------------------------------------------------------------
// conv_output_streamer_if
// Pixel stream bundle between the convolution output streamer and its
// downstream consumer (pooling stage or host readback path).
//
// Handshake: a beat transfers on a rising clock edge when pixValid and pixReady
// are both 1. Once pixValid is raised it stays high, and pixOut, pixEol,
// pixLast, rowIdx and colIdx hold stable, until that transfer happens.
// pixReady may be driven freely by the consumer; it is ignored when pixValid=0.
//
// Signals:
//   pixOut   - current pixel value
//   pixValid - pixOut and the markers are valid
//   pixReady - consumer accepts the current pixel
//   pixEol   - current pixel is the last of its row
//   pixLast  - current pixel is the last of the frame
//   rowIdx   - row of the current pixel
//   colIdx   - column of the current pixel
// Modports: master = streamer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface conv_output_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] pixOut;
    logic                  pixValid;
    logic                  pixReady;
    logic                  pixEol;
    logic                  pixLast;
    logic [3:0]            rowIdx;
    logic [3:0]            colIdx;

    modport master (
        output pixOut, pixValid, pixEol, pixLast, rowIdx, colIdx,
        input  pixReady
    );

    modport slave (
        input  pixOut, pixValid, pixEol, pixLast, rowIdx, colIdx,
        output pixReady
    );
endinterface

// File: rtl/conv_output_streamer.sv
// -----------------------------------------------------------------------------
// conv_output_streamer
// Latches the flat (H-F+1)x(W-F+1) feature-map bus of the convolution layer in
// one cycle and replays it as a row-major pixel stream with end-of-row and
// end-of-frame markers. The latched copy lets the conv layer start on the next
// frame while this one is still draining.
//
// Optional feature: define STREAM_RELU_EN to clamp negative pixels (MSB set)
// to zero at the output. The buffer always holds raw data.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   featureMap - flat feature map, pixel k at [k*DATA_WIDTH +: DATA_WIDTH],
//                k = row*OW + col
//   capture    - one-cycle request to latch featureMap
//   busy       - a frame is held or streaming
//   overrun    - sticky: a capture arrived while busy and was dropped
//   dbg_state  - current FSM state (0 = IDLE, 1 = STREAM)
//   pix        - pixel stream bundle (master side)
// -----------------------------------------------------------------------------
module conv_output_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int H          = 8,
    parameter int W          = 8,
    parameter int F          = 3
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [0:(H-F+1)*(W-F+1)*DATA_WIDTH-1]          featureMap,
    input  logic                                           capture,
    output logic                                           busy,
    output logic                                           overrun,
    output logic                                           dbg_state,
    conv_output_streamer_if.master                         pix
);

    localparam int OH = H - F + 1;
    localparam int OW = W - F + 1;
    localparam int N  = OH * OW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] pix_mem [N];
    logic [IW-1:0]         idx;
    logic [3:0]            row;
    logic [3:0]            col;
    logic [DATA_WIDTH-1:0] raw_pix;

    logic xfer;
    logic at_last;
    logic at_eol;
    logic end_xfer;
    logic load;

    // pixValid is 1 throughout STREAM, so a transfer only needs pixReady.
    assign xfer     = (state == STREAM) && pix.pixReady;
    assign at_last  = (idx == IW'(N - 1));
    assign at_eol   = (col == 4'(OW - 1));
    assign end_xfer = xfer && at_last;
    // A capture is honoured in IDLE or on the edge that retires the last
    // pixel; that second case gives back-to-back frames with no bubble.
    assign load     = capture && ((state == IDLE) || end_xfer);

    assign raw_pix   = pix_mem[idx];
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (end_xfer && !capture) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic: everything is gated by state so reset and IDLE show zeros
    // regardless of the (unreset) buffer contents.
    always_comb begin
        busy         = 1'b0;
        pix.pixValid = 1'b0;
        pix.pixOut   = '0;
        pix.pixEol   = 1'b0;
        pix.pixLast  = 1'b0;
        pix.rowIdx   = '0;
        pix.colIdx   = '0;
        if (state == STREAM) begin
            busy         = 1'b1;
            pix.pixValid = 1'b1;
`ifdef STREAM_RELU_EN
            pix.pixOut   = raw_pix[DATA_WIDTH-1] ? '0 : raw_pix;
`else
            pix.pixOut   = raw_pix;
`endif
            pix.pixEol   = at_eol;
            pix.pixLast  = at_last;
            pix.rowIdx   = row;
            pix.colIdx   = col;
        end
    end

    // Frame buffer: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < N; k++) begin
                pix_mem[k] <= featureMap[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pixel index with a row/column counter pair alongside it, so row and
    // column never need a divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (load) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (xfer) begin
            if (at_last) begin
                idx <= '0;
                row <= '0;
                col <= '0;
            end else begin
                idx <= idx + 1'b1;
                if (at_eol) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Sticky overrun: any capture in STREAM that is not on the last-pixel
    // transfer edge is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if ((state == STREAM) && capture && !end_xfer) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_output_streamer.sv
// -----------------------------------------------------------------------------
// tb_conv_output_streamer
// Directed bench for conv_output_streamer with default parameters (N = 36).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_conv_output_streamer;

    localparam int DW = 8;
    localparam int N  = 36;
    localparam int OW = 6;

    logic              clk;
    logic              reset;
    logic [0:N*DW-1]   featureMap;
    logic              capture;
    logic              busy;
    logic              overrun;
    logic              dbg_state;

    conv_output_streamer_if #(.DATA_WIDTH(DW)) pix_if ();

    conv_output_streamer #(
        .DATA_WIDTH(DW), .H(8), .W(8), .F(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .featureMap (featureMap),
        .capture    (capture),
        .busy       (busy),
        .overrun    (overrun),
        .dbg_state  (dbg_state),
        .pix        (pix_if.master)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] raw_pix [N];
    logic [DW-1:0] exp_q [$];
    logic [0:N*DW-1] fm_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_pix(input logic [DW-1:0] v);
`ifdef STREAM_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Pack raw_pix into a bus and append its expected stream to exp_q.
    task automatic build_frame(output logic [0:N*DW-1] fm);
        for (int k = 0; k < N; k++) begin
            fm[k*DW +: DW] = raw_pix[k];
            exp_q.push_back(exp_pix(raw_pix[k]));
        end
    endtask

    task automatic fill_count(input int base);
        for (int k = 0; k < N; k++) raw_pix[k] = DW'(k + base);
    endtask

    // Pulse capture with a fresh frame; returns at the next falling edge.
    task automatic start_frame();
        logic [0:N*DW-1] fm;
        build_frame(fm);
        featureMap = fm;
        capture = 1'b1;
        @(posedge clk);
        @(negedge clk);
        capture = 1'b0;
        check("first_valid_latency", pix_if.pixValid, 1);
    endtask

    // Consume nbeats pixels. mode 0: ready always high; mode 1: ready 1,0,0,1.
    task automatic stream(input int mode, input int nbeats, input bit chg3,
                          input bit cap20, input bit caplast);
        int beat = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [DW-1:0] h_out;
        logic [3:0] h_row, h_col;
        logic h_eol, h_last;
        logic [DW-1:0] e;
        while (beat < nbeats && cyc < 400) begin
            capture = 1'b0;
            pix_if.pixReady = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            check("valid_held", pix_if.pixValid, 1);
            if (stalled) begin
                check("stall_out", pix_if.pixOut, h_out);
                check("stall_row", pix_if.rowIdx, h_row);
                check("stall_col", pix_if.colIdx, h_col);
                check("stall_eol", pix_if.pixEol, h_eol);
                check("stall_last", pix_if.pixLast, h_last);
            end
            stalled = 0;
            if (chg3 && beat == 3) featureMap = '1;
            if (pix_if.pixValid) begin
                if (pix_if.pixReady) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    check("pix_out", pix_if.pixOut, e);
                    check("row_idx", pix_if.rowIdx, beat / OW);
                    check("col_idx", pix_if.colIdx, beat % OW);
                    check("pix_eol", pix_if.pixEol, (beat % OW) == OW - 1);
                    check("pix_last", pix_if.pixLast, beat == N - 1);
                    if (cap20 && beat == 20) capture = 1'b1;
                    if (caplast && beat == N - 1) begin
                        featureMap = fm_next;
                        capture = 1'b1;
                    end
                    beat++;
                end else begin
                    stalled = 1;
                    h_out = pix_if.pixOut;
                    h_row = pix_if.rowIdx;
                    h_col = pix_if.colIdx;
                    h_eol = pix_if.pixEol;
                    h_last = pix_if.pixLast;
                end
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        capture = 1'b0;
        check("beats_done", beat, nbeats);
    endtask

    initial begin
        reset = 1'b0;
        capture = 1'b0;
        featureMap = '0;
        pix_if.pixReady = 1'b0;
        fm_next = '0;
        #12;
        // Reset state
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_valid", pix_if.pixValid, 0);
        check("rst_eol", pix_if.pixEol, 0);
        check("rst_last", pix_if.pixLast, 0);
        check("rst_out", pix_if.pixOut, 0);
        check("rst_row", pix_if.rowIdx, 0);
        check("rst_col", pix_if.colIdx, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // pixReady is ignored in IDLE
        pix_if.pixReady = 1'b1;
        @(negedge clk);
        check("idle_valid", pix_if.pixValid, 0);
        check("idle_busy", busy, 0);

        // Full frame, ready always high, values 1..36
        fill_count(1);
        start_frame();
        stream(0, N, 0, 0, 0);
        check("eof_valid", pix_if.pixValid, 0);
        check("eof_busy", busy, 0);

        // Same frame with ready toggling 1,0,0,1
        start_frame();
        stream(1, N, 0, 0, 0);
        check("toggle_eof_valid", pix_if.pixValid, 0);

        // Change featureMap to all ones at beat 3: latched copy still streams
        start_frame();
        stream(0, N, 1, 0, 0);
        check("chg_eof_valid", pix_if.pixValid, 0);
        check("overrun_clear", overrun, 0);

        // Capture at beat 20 dropped (overrun), capture on last edge chains
        // straight into a frame starting 0x80, 0xFF, 0x7F, 0x00.
        start_frame();
        fill_count(101);
        raw_pix[0] = 8'h80;
        raw_pix[1] = 8'hFF;
        raw_pix[2] = 8'h7F;
        raw_pix[3] = 8'h00;
        build_frame(fm_next);
        stream(0, N, 0, 1, 1);
        check("overrun_set", overrun, 1);
        check("chain_valid", pix_if.pixValid, 1);
        check("chain_busy", busy, 1);
        check("chain_row", pix_if.rowIdx, 0);
        check("chain_col", pix_if.colIdx, 0);
`ifdef STREAM_RELU_EN
        check("chain_pix0", pix_if.pixOut, 8'h00);
`else
        check("chain_pix0", pix_if.pixOut, 8'h80);
`endif
        stream(0, N, 0, 0, 0);
        check("chain_eof_valid", pix_if.pixValid, 0);
        check("overrun_sticky", overrun, 1);

        // Reset mid-stream at pixel 10
        fill_count(1);
        start_frame();
        stream(0, 10, 0, 0, 0);
        check("pre_rst_out", pix_if.pixOut, 11);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", pix_if.pixValid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out", pix_if.pixOut, 0);
        check("mid_rst_row", pix_if.rowIdx, 0);
        check("mid_rst_col", pix_if.colIdx, 0);
        check("mid_rst_eol", pix_if.pixEol, 0);
        check("mid_rst_overrun", overrun, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        pix_if.pixReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", pix_if.pixValid, 0);
            check("post_rst_overrun", overrun, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_output_streamer.md
Name: conv_output_streamer

Overview:
- Output-side reader for the single-channel convolution layer.
- Captures the flat (H-F+1)x(W-F+1) feature-map bus in one cycle and replays it as a row-major pixel stream over a valid/ready handshake, with end-of-row and end-of-frame markers.
- Sits between the conv layer's outputConv bus and downstream pooling, or a host readback path.
- Decouples the conv layer's wide parallel result from narrow consumers, and holds a stable copy so the conv layer can start the next frame.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- H, 8, input image height.
- W, 8, input image width.
- F, 3, kernel size. Derived values:
  - OH = H-F+1, output rows.
  - OW = W-F+1, output columns.
  - N = OH*OW, pixels per frame.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- featureMap  input  [0:N*DATA_WIDTH-1]  flat feature map. Pixel k is at bits [k*DATA_WIDTH +: DATA_WIDTH], k = row*OW + col, pixel 0 at bit 0.
- capture  input  1  one-cycle request to latch featureMap.
- busy  output  1  high while a frame is held or streaming.
- overrun  output  1  sticky; a capture arrived while busy and was dropped.
- pixOut  output  DATA_WIDTH  current pixel.
- pixValid  output  1  pixOut is valid.
- pixReady  input  1  downstream accepts the pixel.
- pixEol  output  1  current pixel is the last in its row (col = OW-1).
- pixLast  output  1  current pixel is the last of the frame (k = N-1).
- rowIdx  output  4  row of the current pixel.
- colIdx  output  4  column of the current pixel.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - busy, overrun, pixValid, pixEol and pixLast are 0.
  - pixOut, rowIdx and colIdx are 0.
  - Buffer contents are don't-care.
  - Applies immediately mid-stream; the partial frame is discarded and no further beats are issued.
- States: IDLE and STREAM.
- IDLE:
  - pixValid = 0 and busy = 0.
  - capture = 1 at a rising edge: copy featureMap into the internal N*DATA_WIDTH buffer, clear the index, and enter STREAM.
  - Latency from capture edge to first pixValid is 1 cycle. pixValid is high in the cycle after capture is sampled.
- STREAM:
  - pixValid = 1 and busy = 1.
  - pixOut = buffer pixel at the index; rowIdx/colIdx are decoded from the index with a row/column counter pair, not a divider.
  - pixEol = (colIdx == OW-1).
  - pixLast = (index == N-1).
- Handshake:
  - A beat transfers on a rising edge with pixValid & pixReady.
  - While pixValid = 1 and pixReady = 0, pixOut, pixEol, pixLast, rowIdx and colIdx hold stable. pixValid never drops without a transfer.
  - A transfer with colIdx < OW-1 gives colIdx+1.
  - A transfer with colIdx = OW-1 gives colIdx = 0 and rowIdx+1.
- End of frame:
  - A transfer with pixLast = 1 and capture = 0 returns to IDLE; pixValid is 0 the next cycle.
  - If capture = 1 on that same edge, the new featureMap is latched, the index is cleared, and the block stays in STREAM. Pixel 0 of the next frame is valid the next cycle, with no bubble.
- Dropped capture:
  - capture = 1 in STREAM on any edge other than a pixLast transfer is ignored, and overrun is set to 1.
  - overrun clears only on reset.
- Buffer: the conv layer may change featureMap freely after capture; only the latched copy is streamed.
- pixReady is ignored in IDLE.
- Throughput is 1 pixel per cycle with pixReady held high, so a full frame takes N cycles after the first valid.

Optional Feature:
- Macro STREAM_RELU_EN.
- When defined, pixOut is clamped: if the pixel MSB (two's-complement sign) is 1, output 0; otherwise pass the pixel unchanged. The clamp is applied combinationally at the output; the buffer stores raw data. No latency change.
- When undefined, the raw buffered pixel is output.
- Handshake, markers and index outputs are identical in both builds.

Test Plan:
1. Reset low mid-stream at pixel 10 -> outputs go to 0 immediately, with no beats after reset goes high until a new capture; overrun = 0.
2. Default params (N=36), featureMap pixel k = k+1, capture pulse, pixReady = 1 -> 36 beats on consecutive cycles with values 1..36.
   - pixEol on beats 6, 12, …, 36; pixLast only on beat 36.
   - rowIdx/colIdx run (0,0) to (5,5); pixValid = 0 on the cycle after beat 36.
3. Same frame with pixReady toggling 1,0,0,1,… -> exactly 36 transfers, values 1..36 in order, pixOut stable during every stall cycle.
4. Capture, then change featureMap to all 0xFF at beat 3 -> streamed values are still 1..36.
5. Capture pulsed at beat 20 -> the pulse is ignored and overrun = 1.
   - Capture on the pixLast transfer edge -> the next frame's pixel 0 is valid the following cycle, with no IDLE bubble.
6. With STREAM_RELU_EN defined, pixels 0x80, 0xFF, 0x7F, 0x00 -> output 0x00, 0x00, 0x7F, 0x00.
   - Without STREAM_RELU_EN -> output 0x80, 0xFF, 0x7F, 0x00.
